// File: rtl/dlx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dlx_pkg
// Shared DLX definitions: instruction width, NOP encoding, the fetch-stage
// state type and the primary opcode values the decode stage also uses.
// Rev 1.0
// ----------------------------------------------------------------------------
package dlx_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // All-zero word decodes as a harmless NOP, so an empty fetch slot is safe.
  localparam logic [INST_W-1:0] DLX_NOP = 32'h0000_0000;

  // Primary opcode field position within an instruction word.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // Control-transfer opcodes resolved downstream and fed back as redirects.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQZ    = 6'h04;
  localparam logic [5:0] OP_BNEZ    = 6'h05;
  localparam logic [5:0] OP_JR      = 6'h12;
  localparam logic [5:0] OP_JALR    = 6'h13;

  // Fetch-stage states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } ifetch_state_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_32_lookahead.sv
`default_nettype none
// ----------------------------------------------------------------------------
// add_32_lookahead
// 32-bit modulo adder: carry lookahead inside 4-bit groups, group carries
// chained between groups. Carry out is not produced; results wrap.
// Rev 1.0
// ----------------------------------------------------------------------------
module add_32_lookahead (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  // Bit 31 generate would only feed a carry-out, which this adder drops.
  logic [30:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gc;

  assign g = a[30:0] & b[30:0];
  assign p = a ^ b;

  // Group carries first, then the lookahead carries inside every group.
  always_comb begin
    gc    = '0;
    c     = '0;
    gc[0] = cin;
    for (int j = 0; j < 7; j++) begin
      gc[j+1] = g[4*j+3]
              | (p[4*j+3] & g[4*j+2])
              | (p[4*j+3] & p[4*j+2] & g[4*j+1])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
              | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign sum = p ^ c;

endmodule
`default_nettype wire

// File: rtl/register_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// register_n
// N-bit load-enabled register with asynchronous active-low reset to a
// parameterised value.
// Rev 1.0
// ----------------------------------------------------------------------------
module register_n #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Load d when enabled, otherwise hold; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlx_ifetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dlx_ifetch
// DLX instruction-fetch stage. Owns the PC, fetches over a req/ack memory
// handshake, presents one instruction with its PC to decode, and follows
// branch/jump redirects while throwing away fetches they make stale.
// Rev 1.0
// ----------------------------------------------------------------------------
module dlx_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  import dlx_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = 32'(PC_STEP);

  ifetch_state_t     state;
  ifetch_state_t     next_state;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_en;
  logic [ADDR_W-1:0] fetch_d;
  logic              fetch_en;
  logic              inst_en;
  logic [ADDR_W-1:0] pc_plus;
  logic [ADDR_W-1:0] target;

  assign target = word_align(redirect_pc);

  // Next PC after a successful fetch is always relative to the fetched word.
  add_32_lookahead u_pc_adder (
    .a   (imem_addr),
    .b   (STEP),
    .cin (1'b0),
    .sum (pc_plus)
  );

  // PC: address the next new request will use.
  register_n #(.N(ADDR_W), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc)
  );

  // Fetch address: only reloaded when no request is left hanging at memory.
  register_n #(.N(ADDR_W), .RESET_VAL(RESET_PC)) u_fetch_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetch_en),
    .d     (fetch_d),
    .q     (imem_addr)
  );

  register_n #(.N(INST_W), .RESET_VAL(DLX_NOP)) u_inst_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (inst_en),
    .d     (imem_rdata),
    .q     (inst)
  );

  register_n #(.N(ADDR_W), .RESET_VAL('0)) u_inst_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (inst_en),
    .d     (imem_addr),
    .q     (inst_pc)
  );

  // Transition and register-load decisions for the current state and inputs.
  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    pc_d       = pc;
    fetch_en   = 1'b0;
    fetch_d    = pc;
    inst_en    = 1'b0;
    case (state)
      IDLE: begin
        // A redirect arriving before the first request steers that request.
        next_state = REQ;
        fetch_en   = 1'b1;
        if (redirect) begin
          pc_en   = 1'b1;
          pc_d    = target;
          fetch_d = target;
        end
      end
      REQ: begin
        if (imem_ack && !redirect) begin
          inst_en    = 1'b1;
          pc_en      = 1'b1;
          pc_d       = pc_plus;
          next_state = HOLD;
        end else if (imem_ack) begin
          // Word returned is already stale: restart straight at the target.
          pc_en    = 1'b1;
          pc_d     = target;
          fetch_en = 1'b1;
          fetch_d  = target;
        end else if (redirect) begin
          // Request still pending: address must stay put until ack.
          pc_en      = 1'b1;
          pc_d       = target;
          next_state = DROP;
        end
      end
      DROP: begin
        // Later redirects replace earlier ones; a same-cycle one wins over pc.
        if (redirect) begin
          pc_en = 1'b1;
          pc_d  = target;
        end
        if (imem_ack) begin
          fetch_en   = 1'b1;
          fetch_d    = redirect ? target : pc;
          next_state = REQ;
        end
      end
      HOLD: begin
        // Redirect retires the held instruction even if decode is not ready.
        if (redirect) begin
          pc_en      = 1'b1;
          pc_d       = target;
          fetch_en   = 1'b1;
          fetch_d    = target;
          next_state = REQ;
        end else if (dec_ready) begin
          fetch_en   = 1'b1;
          fetch_d    = pc;
          next_state = REQ;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State plus registered handshake outputs; reset drops the request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= next_state;
      imem_req   <= (next_state == REQ) || (next_state == DROP);
      inst_valid <= (next_state == HOLD);
    end
  end

endmodule
`default_nettype wire
